mem_port_arbiter: RTL and testbench

Two-requester arbiter sharing one unified memory port between the core's instruction-fetch interface and its data interface. It sits between the core and a single-ported memory or bus bridge. It serialises fetches and loads/stores with a req/ack handshake, a registered downstream request and an optional abort watchdog. Grant policy is fixed data-priority, or round-robin when compiled in.

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - core-side and memory-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] i_instr_addr;
  logic            i_instr_req;
  logic [XLEN-1:0] o_instr_data;
  logic            o_instr_ack;

  logic [XLEN-1:0] i_data_addr;
  logic [XLEN-1:0] i_data_wr_data;
  logic [1:0]      i_data_mask;
  logic            i_data_wr_en;
  logic            i_data_req;
  logic [XLEN-1:0] o_data_rd_data;
  logic            o_data_ack;

  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wr_data;
  logic [1:0]      o_mem_mask;
  logic            o_mem_wr_en;
  logic            o_mem_req;
  logic [XLEN-1:0] i_mem_rd_data;
  logic            i_mem_ack;

  logic            o_timeout;
  logic            o_busy;

  // The arbiter itself takes the slave view.
  modport slave (
    input  i_instr_addr, i_instr_req,
    output o_instr_data, o_instr_ack,
    input  i_data_addr, i_data_wr_data, i_data_mask, i_data_wr_en, i_data_req,
    output o_data_rd_data, o_data_ack,
    output o_mem_addr, o_mem_wr_data, o_mem_mask, o_mem_wr_en, o_mem_req,
    input  i_mem_rd_data, i_mem_ack,
    output o_timeout, o_busy
  );

  modport master (
    output i_instr_addr, i_instr_req,
    input  o_instr_data, o_instr_ack,
    output i_data_addr, i_data_wr_data, i_data_mask, i_data_wr_en, i_data_req,
    input  o_data_rd_data, o_data_ack,
    input  o_mem_addr, o_mem_wr_data, o_mem_mask, o_mem_wr_en, o_mem_req,
    output i_mem_rd_data, i_mem_ack,
    input  o_timeout, o_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto one memory port; ARB_RR_EN selects round-robin ties
module mem_port_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam bit          WD_EN   = (TIMEOUT > 0);
  localparam logic [15:0] WD_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  state_t          state_q;
  state_t          state_d;
  logic            busy_q;
  logic [15:0]     wd_cnt_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wr_data_q;
  logic [1:0]      mem_mask_q;
  logic            mem_wr_en_q;

  logic in_gnt;
  logic wd_expire;
  logic txn_done;
  logic any_req;
  logic grant_d;

  assign in_gnt    = (state_q == GNT_I) || (state_q == GNT_D);
  assign wd_expire = WD_EN && in_gnt && (wd_cnt_q == WD_LAST);
  assign txn_done  = in_gnt && (bus.i_mem_ack || wd_expire);
  assign any_req   = bus.i_instr_req || bus.i_data_req;

`ifdef ARB_RR_EN
  // Set when data owned the most recent completed or aborted transaction.
  logic last_d_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_d_q <= 1'b0;
    end else if (txn_done) begin
      last_d_q <= (state_q == GNT_D);
    end
  end

  assign grant_d = bus.i_data_req && (!bus.i_instr_req || !last_d_q);
`else
  assign grant_d = bus.i_data_req;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = GNT_D;
        end else if (bus.i_instr_req) begin
          state_d = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (txn_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_instr_ack    = 1'b0;
    bus.o_instr_data   = '0;
    bus.o_data_ack     = 1'b0;
    bus.o_data_rd_data = '0;
    // A real ack in the expiry cycle takes precedence over the abort.
    bus.o_timeout      = wd_expire && !bus.i_mem_ack;
    case (state_q)
      GNT_I: begin
        bus.o_instr_ack = txn_done;
        if (bus.i_mem_ack) begin
          bus.o_instr_data = bus.i_mem_rd_data;
        end
      end
      GNT_D: begin
        bus.o_data_ack = txn_done;
        if (bus.i_mem_ack) begin
          bus.o_data_rd_data = bus.i_mem_rd_data;
        end
      end
      default: ;
    endcase
  end

  // Winner's request is captured once at grant; requester changes afterwards are ignored.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_mask_q    <= 2'b00;
      mem_wr_en_q   <= 1'b0;
    end else if ((state_q == IDLE) && any_req) begin
      if (grant_d) begin
        mem_addr_q    <= bus.i_data_addr;
        mem_wr_data_q <= bus.i_data_wr_data;
        mem_mask_q    <= bus.i_data_mask;
        mem_wr_en_q   <= bus.i_data_wr_en;
      end else begin
        mem_addr_q    <= bus.i_instr_addr;
        mem_wr_data_q <= '0;
        mem_mask_q    <= 2'b11;
        mem_wr_en_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_cnt_q <= '0;
    end else if (in_gnt && !txn_done) begin
      wd_cnt_q <= wd_cnt_q + 16'd1;
    end else begin
      wd_cnt_q <= '0;
    end
  end

  assign bus.o_mem_req     = busy_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_mem_addr    = mem_addr_q;
  assign bus.o_mem_wr_data = mem_wr_data_q;
  assign bus.o_mem_mask    = mem_mask_q;
  assign bus.o_mem_wr_en   = mem_wr_en_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (TIMEOUT=8)
module tb_mem_port_arbiter;
  localparam int XLEN = 32;
  localparam int TO   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.XLEN(XLEN)) bus ();

  mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mask;
    logic        wr_en;
    logic [31:0] rdata;
    logic        tmo;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mask;
    logic        wr_en;
  } dreq_t;

  exp_t        exp_q[$];
  logic [31:0] ireq_q[$];
  dreq_t       dreq_q[$];
  int          ack_cyc_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int i_ack_cnt = 0;
  int d_ack_cnt = 0;
  int mem_mode = 0;  // 0 manual, 1 fixed latency, 2 never ack, 3 zero-wait
  int mem_lat = 1;
  logic        man_ack = 1'b0;
  logic [31:0] man_rd = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[15:0], 16'h5A00} ^ 32'h0000_00C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_i(input logic [31:0] a, input logic tmo);
    exp_t e;
    e.is_d = 1'b0; e.addr = a; e.wdata = 32'h0; e.mask = 2'b11; e.wr_en = 1'b0;
    e.rdata = tmo ? 32'h0 : mem_word(a); e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  task automatic exp_d(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] m,
                       input logic we, input logic tmo);
    exp_t e;
    e.is_d = 1'b1; e.addr = a; e.wdata = wd; e.mask = m; e.wr_en = we;
    e.rdata = tmo ? 32'h0 : mem_word(a); e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  task automatic req_d(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] m,
                       input logic we);
    dreq_t r;
    r.addr = a; r.wdata = wd; r.mask = m; r.wr_en = we;
    dreq_q.push_back(r);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req_busy"}, 32'({bus.o_mem_req, bus.o_busy}), 32'd0);
    check({tag, "_mem_addr"}, bus.o_mem_addr, 32'd0);
    check({tag, "_mem_wr_data"}, bus.o_mem_wr_data, 32'd0);
    check({tag, "_mem_mask_wr_en"}, 32'({bus.o_mem_mask, bus.o_mem_wr_en}), 32'd0);
    check({tag, "_acks_timeout"}, 32'({bus.o_instr_ack, bus.o_data_ack, bus.o_timeout}), 32'd0);
    check({tag, "_rd_data"}, bus.o_instr_data | bus.o_data_rd_data, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || ireq_q.size() != 0 || dreq_q.size() != 0 ||
                bus.i_instr_req || bus.i_data_req || bus.o_busy) && n < 200);
    if (n >= 200) check("drain_bound_expired", 32'd1, 32'd0);
  endtask

  // Memory responder: drives i_mem_ack just after each rising edge.
  initial begin : responder
    int gcnt = 0;
    bus.i_mem_ack = 1'b0;
    bus.i_mem_rd_data = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      gcnt = bus.o_mem_req ? gcnt + 1 : 0;
      bus.i_mem_ack = 1'b0;
      bus.i_mem_rd_data = 32'h0;
      case (mem_mode)
        0: begin
          bus.i_mem_ack = man_ack;
          bus.i_mem_rd_data = man_rd;
        end
        1: if (bus.o_mem_req && gcnt == mem_lat) begin
          bus.i_mem_ack = 1'b1;
          bus.i_mem_rd_data = mem_word(bus.o_mem_addr);
        end
        3: if (bus.o_mem_req) begin
          bus.i_mem_ack = 1'b1;
          bus.i_mem_rd_data = mem_word(bus.o_mem_addr);
        end
        default: ;
      endcase
    end
  end

  initial begin : instr_requester
    int seen = 0;
    bus.i_instr_req = 1'b0;
    bus.i_instr_addr = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.i_instr_req = 1'b0;
        ireq_q.delete();
        seen = i_ack_cnt;
      end else begin
        if (i_ack_cnt != seen) begin
          seen = i_ack_cnt;
          bus.i_instr_req = 1'b0;
        end
        if (!bus.i_instr_req && ireq_q.size() != 0) begin
          bus.i_instr_addr = ireq_q.pop_front();
          bus.i_instr_req = 1'b1;
        end
      end
    end
  end

  initial begin : data_requester
    int seen = 0;
    dreq_t r;
    bus.i_data_req = 1'b0;
    bus.i_data_addr = 32'h0;
    bus.i_data_wr_data = 32'h0;
    bus.i_data_mask = 2'b00;
    bus.i_data_wr_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.i_data_req = 1'b0;
        dreq_q.delete();
        seen = d_ack_cnt;
      end else begin
        if (d_ack_cnt != seen) begin
          seen = d_ack_cnt;
          bus.i_data_req = 1'b0;
        end
        if (!bus.i_data_req && dreq_q.size() != 0) begin
          r = dreq_q.pop_front();
          bus.i_data_addr = r.addr;
          bus.i_data_wr_data = r.wdata;
          bus.i_data_mask = r.mask;
          bus.i_data_wr_en = r.wr_en;
          bus.i_data_req = 1'b1;
        end
      end
    end
  end

  // Scoreboard monitor: pops one expectation per requester ack.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.o_instr_ack || bus.o_data_ack) begin
          check("single_owner_ack", 32'(bus.o_instr_ack & bus.o_data_ack), 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'({bus.o_instr_ack, bus.o_data_ack}), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("ack_channel", 32'(bus.o_data_ack), 32'(e.is_d));
            check("ack_rd_data", e.is_d ? bus.o_data_rd_data : bus.o_instr_data, e.rdata);
            check("ack_timeout", 32'(bus.o_timeout), 32'(e.tmo));
            check("mem_addr", bus.o_mem_addr, e.addr);
            check("mem_wr_data", bus.o_mem_wr_data, e.wdata);
            check("mem_mask_wr_en", 32'({bus.o_mem_mask, bus.o_mem_wr_en}), 32'({e.mask, e.wr_en}));
          end
          ack_cyc_q.push_back(cyc);
          if (bus.o_instr_ack) i_ack_cnt++;
          if (bus.o_data_ack) d_ack_cnt++;
        end else begin
          check("quiet_rd_data", bus.o_instr_data | bus.o_data_rd_data, 32'd0);
          check("quiet_timeout", 32'(bus.o_timeout), 32'd0);
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    int cnt;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Single fetch, memory acks in the third grant cycle.
    mem_mode = 1; mem_lat = 3;
    exp_i(32'h0000_0100, 1'b0);
    ireq_q.push_back(32'h0000_0100);
    drain();

    // Simultaneous fetch and store: store first, fetch after one IDLE cycle.
    exp_d(32'h0000_2000, 32'hDEAD_BEEF, 2'b11, 1'b1, 1'b0);
    exp_i(32'h0000_0104, 1'b0);
    req_d(32'h0000_2000, 32'hDEAD_BEEF, 2'b11, 1'b1);
    ireq_q.push_back(32'h0000_0104);
    drain();

    // Four tie rounds against zero-wait memory.
    mem_mode = 3;
    ack_cyc_q.delete();
`ifdef ARB_RR_EN
    exp_d(32'h0000_3000, 32'h1111_0000, 2'b11, 1'b1, 1'b0);
    exp_i(32'h0000_0200, 1'b0);
    exp_d(32'h0000_3004, 32'h0, 2'b00, 1'b0, 1'b0);
    exp_i(32'h0000_0204, 1'b0);
`else
    exp_d(32'h0000_3000, 32'h1111_0000, 2'b11, 1'b1, 1'b0);
    exp_d(32'h0000_3004, 32'h0, 2'b00, 1'b0, 1'b0);
    exp_i(32'h0000_0200, 1'b0);
    exp_i(32'h0000_0204, 1'b0);
`endif
    req_d(32'h0000_3000, 32'h1111_0000, 2'b11, 1'b1);
    req_d(32'h0000_3004, 32'h0, 2'b00, 1'b0);
    ireq_q.push_back(32'h0000_0200);
    ireq_q.push_back(32'h0000_0204);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_busy && n < 20);
    check("busy_start_bound", 32'(bus.o_busy), 32'd1);
    for (int k = 0; k < 8; k++) begin
      check("busy_toggle", 32'(bus.o_busy), (k % 2 == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    drain();
    check("zero_wait_ack_count", ack_cyc_q.size(), 32'd4);
    for (int k = 1; k < ack_cyc_q.size(); k++) begin
      check("ack_spacing", ack_cyc_q[k] - ack_cyc_q[k-1], 32'd2);
    end

    // Halfword store with single-cycle latency.
    mem_mode = 1; mem_lat = 1;
    exp_d(32'h0000_2002, 32'h0000_BEEF, 2'b01, 1'b1, 1'b0);
    req_d(32'h0000_2002, 32'h0000_BEEF, 2'b01, 1'b1);
    drain();

    // Memory never answers: abort on the 8th GNT_D cycle.
    mem_mode = 2;
    exp_d(32'h0000_4000, 32'h0, 2'b11, 1'b0, 1'b1);
    req_d(32'h0000_4000, 32'h0, 2'b11, 1'b0);
    cnt = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.o_mem_req) cnt++;
    end while (!bus.o_data_ack && n < 40);
    check("timeout_grant_cycles", cnt, 32'd8);
    @(negedge clk);
    check("idle_after_timeout", 32'(bus.o_busy), 32'd0);
    drain();

    // Ack lands exactly on the expiry cycle: normal completion.
    mem_mode = 1; mem_lat = 8;
    exp_d(32'h0000_4004, 32'h0, 2'b11, 1'b0, 1'b0);
    req_d(32'h0000_4004, 32'h0, 2'b11, 1'b0);
    drain();

    // Reset in GNT_I, then a stray ack after release.
    mem_mode = 0; man_ack = 1'b0;
    ireq_q.push_back(32'h0000_0300);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_busy && n < 20);
    check("fetch_granted_before_reset", 32'(bus.o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    man_rd = 32'hCAFE_F00D;
    man_ack = 1'b1;
    @(negedge clk);
    check("stray_ack_no_requester_ack", 32'({bus.o_instr_ack, bus.o_data_ack}), 32'd0);
    check("stray_ack_rd_data", bus.o_instr_data | bus.o_data_rd_data, 32'd0);
    check("stray_ack_busy", 32'(bus.o_busy), 32'd0);
    man_ack = 1'b0;
    @(negedge clk);

    check("exp_queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
